// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage (WB)
// and a long-latency unit (MU) with a one-entry MU holding buffer and starvation guard.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mu_valid,
  output logic              mu_ready,
  input  logic [ADDR_W-1:0] mu_reg,
  input  logic [DATA_W-1:0] mu_data,
  output logic              regwrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              mu_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] buf_reg_q, buf_reg_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              stall_q, stall_d;
  logic              mu_drop_q, mu_drop_d;
  logic              wb_req_s;
  logic              mu_xfer_s;
  logic [3:0]        cnt_inc_s;

  assign wb_req_s  = wb_valid && (wb_reg != '0);
  assign mu_ready  = (state_q == IDLE);
  assign mu_xfer_s = mu_valid && mu_ready;
  assign cnt_inc_s = cnt_q + 4'd1;

  assign regwrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign stall      = stall_q;
  assign mu_drop    = mu_drop_q;

  // State, buffer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      buf_reg_q    <= '0;
      buf_data_q   <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      stall_q      <= 1'b0;
      mu_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_reg_q    <= buf_reg_d;
      buf_data_q   <= buf_data_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      stall_q      <= stall_d;
      mu_drop_q    <= mu_drop_d;
    end
  end

  // Next state, wait counter and holding buffer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_reg_d  = buf_reg_q;
    buf_data_d = buf_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        // A transfer to register 0 is accepted and silently dropped
        if (mu_xfer_s && (mu_reg != '0)) begin
          buf_reg_d  = mu_reg;
          buf_data_d = mu_data;
          state_d    = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (wb_req_s) begin
          if (wb_reg == buf_reg_q) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_inc_s >= MaxWait) begin
            state_d = FORCE;
            cnt_d   = cnt_inc_s;
          end else begin
            state_d = PEND;
            cnt_d   = cnt_inc_s;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      FORCE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Write-port grant and status outputs for the next cycle
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    mu_drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_req_s) begin
          regwrite_d   = 1'b1;
          write_reg_d  = wb_reg;
          write_data_d = wb_data;
        end else begin
          regwrite_d = 1'b0;
        end
      end
      PEND: begin
        // WB is younger in program order, so a same-register WB kills the buffer
        if (wb_req_s) begin
          regwrite_d   = 1'b1;
          write_reg_d  = wb_reg;
          write_data_d = wb_data;
          mu_drop_d    = (wb_reg == buf_reg_q);
        end else begin
          regwrite_d   = 1'b1;
          write_reg_d  = buf_reg_q;
          write_data_d = buf_data_q;
        end
      end
      FORCE: begin
        regwrite_d   = 1'b1;
        write_reg_d  = buf_reg_q;
        write_data_d = buf_data_q;
      end
      default: begin
        regwrite_d = 1'b0;
      end
    endcase
    stall_d = (state_d == FORCE);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes (register, data, cycle)
// are queued by the stimulus and checked by an independent monitor.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          mu_valid;
  logic          mu_ready;
  logic [AW-1:0] mu_reg;
  logic [DW-1:0] mu_data;
  logic          regwrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          stall;
  logic          mu_drop;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  wr_t exp_q[$];

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_reg(mu_reg), .mu_data(mu_data),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .stall(stall), .mu_drop(mu_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] r, input logic [DW-1:0] d, input int lat);
    wr_t e;
    e.r = r;
    e.d = d;
    e.c = cyc + lat;
    exp_q.push_back(e);
  endtask

  // Monitor: every write on the port must match the next queued expectation
  always @(negedge clk) begin
    if (reset && regwrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_reg", DW'(write_reg), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_reg", DW'(write_reg), DW'(e.r));
        check("write_data", write_data, e.d);
        check("write_cycle", DW'(cyc), DW'(e.c));
      end
    end
  end

  initial begin
    reset = 1'b0; wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0033;
    mu_valid = 1'b0; mu_reg = 5'd0; mu_data = 32'h0;

    // Reset held with a pending WB request
    repeat (3) tick();
    check("rst_regwrite", DW'(regwrite), 32'd0);
    check("rst_stall", DW'(stall), 32'd0);
    check("rst_mu_ready", DW'(mu_ready), 32'd1);
    check("rst_mu_drop", DW'(mu_drop), 32'd0);
    reset = 1'b1;
    expect_wr(5'd3, 32'h0000_0033, 1);
    tick();
    wb_valid = 1'b0;
    tick();

    // WB only, then WB to register 0
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF, 1);
    tick();
    wb_reg = 5'd0; wb_data = 32'h5555_5555;
    tick();
    check("wb_reg0_regwrite", DW'(regwrite), 32'd0);
    check("wb_reg0_hold_reg", DW'(write_reg), 32'd5);
    check("wb_reg0_hold_data", write_data, 32'hDEAD_BEEF);
    wb_valid = 1'b0;
    tick();

    // MU on an idle port
    mu_valid = 1'b1; mu_reg = 5'd7; mu_data = 32'h0000_1234;
    check("mu_idle_ready", DW'(mu_ready), 32'd1);
    expect_wr(5'd7, 32'h0000_1234, 2);
    tick();
    mu_valid = 1'b0;
    check("mu_pend_ready", DW'(mu_ready), 32'd0);
    tick();
    check("mu_done_ready", DW'(mu_ready), 32'd1);

    // MU transfer to register 0 is swallowed
    mu_valid = 1'b1; mu_reg = 5'd0; mu_data = 32'hBAD0_0000;
    tick();
    mu_valid = 1'b0;
    check("mu_reg0_ready", DW'(mu_ready), 32'd1);
    tick();

    // Simultaneous WB and MU in IDLE, then WB to reg 0 while pending
    wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'h0000_00A0;
    mu_valid = 1'b1; mu_reg = 5'd11; mu_data = 32'h0000_00B0;
    expect_wr(5'd10, 32'h0000_00A0, 1);
    expect_wr(5'd11, 32'h0000_00B0, 2);
    tick();
    mu_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
    tick();
    wb_valid = 1'b0;
    tick();

    // Starvation: four WB grants, forced MU grant, held WB re-presented
    mu_valid = 1'b1; mu_reg = 5'd9; mu_data = 32'h0000_0099;
    tick();
    mu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = AW'(i); wb_data = 32'h0000_0100 + DW'(i);
      check("starve_no_stall", DW'(stall), 32'd0);
      expect_wr(AW'(i), 32'h0000_0100 + DW'(i), 1);
      tick();
    end
    wb_reg = 5'd5; wb_data = 32'h0000_0105;
    check("force_stall", DW'(stall), 32'd1);
    check("force_mu_ready", DW'(mu_ready), 32'd0);
    expect_wr(5'd9, 32'h0000_0099, 1);
    tick();
    check("force_stall_drop", DW'(stall), 32'd0);
    expect_wr(5'd5, 32'h0000_0105, 1);
    tick();
    wb_valid = 1'b0;
    tick();

    // Collision: WB to the buffered register wins
    mu_valid = 1'b1; mu_reg = 5'd6; mu_data = 32'h0000_0066;
    tick();
    mu_valid = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h0000_00AA;
    check("coll_pre_drop", DW'(mu_drop), 32'd0);
    expect_wr(5'd6, 32'h0000_00AA, 1);
    tick();
    wb_valid = 1'b0;
    check("coll_mu_drop", DW'(mu_drop), 32'd1);
    check("coll_mu_ready", DW'(mu_ready), 32'd1);
    tick();
    check("coll_drop_pulse", DW'(mu_drop), 32'd0);
    repeat (2) tick();

    // Reset while a buffered entry is pending
    mu_valid = 1'b1; mu_reg = 5'd8; mu_data = 32'h0000_0088;
    tick();
    mu_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("midrst_mu_ready", DW'(mu_ready), 32'd1);
    check("midrst_regwrite", DW'(regwrite), 32'd0);
    reset = 1'b1;
    tick();
    check("postrst_mu_ready", DW'(mu_ready), 32'd1);

    // Counter must restart from zero after the reset
    mu_valid = 1'b1; mu_reg = 5'd12; mu_data = 32'h0000_0012;
    tick();
    mu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = AW'(i + 16); wb_data = 32'h0000_0200 + DW'(i);
      expect_wr(AW'(i + 16), 32'h0000_0200 + DW'(i), 1);
      tick();
    end
    wb_valid = 1'b0;
    check("postrst_force_stall", DW'(stall), 32'd1);
    expect_wr(5'd12, 32'h0000_0012, 1);
    repeat (4) tick();

    check("queue_drained", DW'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- Requester 1 is the main pipeline writeback stage (WB). Requester 2 is a long-latency unit (MU), such as multiply/divide or a late load.
- MU results sit in a one-entry holding buffer until the write port is free. A starvation counter stalls the pipeline so that a buffered MU result is written within MAX_WAIT cycles.
- Outputs connect directly to the register file's regwrite/write_reg/write_data inputs.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- MAX_WAIT, 4, number of consecutive denied cycles a buffered MU entry tolerates before a forced grant (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- wb_valid  input  1  WB has a result this cycle (no handshake; WB must hold it while stall=1).
- wb_reg  input  ADDR_W  WB destination register.
- wb_data  input  DATA_W  WB result.
- mu_valid  input  1  MU offers a result.
- mu_ready  output  1  arbiter can accept the MU result; transfer occurs when mu_valid and mu_ready are both 1.
- mu_reg  input  ADDR_W  MU destination register.
- mu_data  input  DATA_W  MU result.
- regwrite  output  1  registered write enable to the register file.
- write_reg  output  ADDR_W  registered write index.
- write_data  output  DATA_W  registered write data.
- stall  output  1  registered; pipeline must freeze WB and hold wb_* stable.
- mu_drop  output  1  registered one-cycle pulse: the buffered MU entry was discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - regwrite, write_reg, write_data, stall and mu_drop all go to 0.
  - Buffer is emptied, wait counter is set to 0, state goes to IDLE.
  - Reset during PEND or FORCE discards the buffered entry with no write.
- States:
  - IDLE: buffer empty.
  - PEND: buffer holds {buf_reg, buf_data}.
  - FORCE: forced-grant cycle.
- mu_ready is 1 only in IDLE, decoded combinationally from state.
- Output timing: all writeback outputs are registered. A grant decided in cycle N appears on regwrite/write_reg/write_data in cycle N+1.
  - WB-to-regwrite latency is 1 cycle.
  - MU transfer to regwrite latency is at least 2 cycles (capture, then grant).
- IDLE:
  - If wb_valid=1 and wb_reg≠0, register a WB write.
  - If the MU transfers with mu_reg≠0, capture it into the buffer and go to PEND with counter=0.
  - An MU transfer with mu_reg=0 is completed and discarded; state stays IDLE and no write is issued.
- PEND:
  - If wb_valid=1 and wb_reg≠0, WB is granted and the counter increments.
    - If wb_reg==buf_reg, the buffer is discarded, mu_drop pulses next cycle, and state returns to IDLE.
    - Rule: WB is program-order younger, so its value stands.
  - If wb_valid=0, or wb_reg=0, the buffer is granted, state goes to IDLE and the counter resets.
  - When the increment takes the counter to MAX_WAIT, the next state is FORCE and stall=1 is registered.
- FORCE (exactly one cycle, stall=1):
  - The buffer is granted unconditionally and wb_* is ignored; the pipeline re-presents it next cycle.
  - Next state is IDLE, stall goes to 0 and the counter resets.
- Writes to register 0 never produce regwrite=1.
- When regwrite=0, write_reg and write_data keep their previous values.
- Simultaneous WB and MU in IDLE: WB is written and MU is captured in the same cycle.
- regwrite is at most one write per cycle, with no back-to-back duplicate of the same entry.

Test Plan:
- Reset: hold reset=0 with wb_valid=1, wb_reg=3 -> regwrite=0, stall=0, mu_ready=1. Release reset -> regwrite=1, write_reg=3 on the next cycle.
- WB only: wb_reg=5, wb_data=0xDEADBEEF for 1 cycle -> next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF. wb_reg=0 -> regwrite=0.
- MU idle port: MU transfer reg=7, data=0x1234 with wb_valid=0 -> mu_ready=0 the next cycle, then regwrite=1, write_reg=7 two cycles after the transfer, then mu_ready=1.
- Starvation (MAX_WAIT=4): buffer reg=9, wb_valid=1 continuously to regs 1..4 -> four WB writes, then stall=1 for one cycle with write_reg=9. The held WB write appears after stall drops.
- Collision: buffer reg=6, WB writes reg=6 value 0xAA -> write_reg=6 with data 0xAA, and mu_drop=1 for one cycle. Reg 6 is never written with the MU value.
- Reset mid-PEND: buffer reg=8, assert reset for 1 cycle -> no write to 8 ever, mu_ready=1, counter=0.
